// File: rtl/calc1_pkg.sv
// Shared types and constants for the four-port calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc1_pkg;

  localparam int DW     = 32;
  localparam int NPORTS = 4;
  localparam int PIDW   = 2;

  typedef logic [DW-1:0]   word_t;
  typedef logic [3:0]      cmd_t;
  typedef logic [1:0]      resp_t;
  typedef logic [PIDW-1:0] port_id_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_ERR  = 2'd2;

  // One fully captured request waiting for the shared operation unit
  typedef struct packed {
    port_id_t port;
    cmd_t     cmd;
    word_t    op1;
    word_t    op2;
  } req_t;

  // Per-port capture state: operand1 cycle, operand2 cycle, waiting for answer
  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_OP2  = 2'd1,
    P_PEND = 2'd2
  } pstate_t;

endpackage

// File: rtl/calc1_alu.sv
// Shared unsigned 32-bit add/subtract/shift unit with error detection.
// Latency: combinational, result settles in the same cycle as the inputs.
// Backpressure: none; the caller registers the outputs.
module calc1_alu
  import calc1_pkg::*;
(
  input  cmd_t            cmd,
  input  word_t           op1,
  input  word_t           op2,
  output logic [0:DW-1]   result,
  output logic [0:1]      resp
);

  logic [DW:0] sum;
  word_t       res_w;
  resp_t       resp_w;

  // Decode the command; any error forces the result to zero
  always_comb begin
    sum    = {1'b0, op1} + {1'b0, op2};
    res_w  = '0;
    resp_w = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DW]) begin
          res_w  = sum[DW-1:0];
          resp_w = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          res_w  = op1 - op2;
          resp_w = RESP_OK;
        end
      end
      CMD_SHL: begin
        res_w  = op1 << op2[4:0];
        resp_w = RESP_OK;
      end
      CMD_SHR: begin
        res_w  = op1 >> op2[4:0];
        resp_w = RESP_OK;
      end
      default: begin
        res_w  = '0;
        resp_w = RESP_ERR;
      end
    endcase
  end

  assign result = res_w;
  assign resp   = resp_w;

endmodule

// File: rtl/calc1_unit.sv
// Four requester ports sharing one calculator, served in arrival order.
// Latency: response 3 cycles after the command cycle, +1 per request queued ahead.
// Backpressure: none; a port ignores commands while it has one outstanding.
module calc1_unit
  import calc1_pkg::*;
(
  input  logic          c_clk,
  input  logic [1:7]    reset,
  input  logic [0:3]    req1_cmd_in,
  input  logic [0:31]   req1_data_in,
  input  logic [0:3]    req2_cmd_in,
  input  logic [0:31]   req2_data_in,
  input  logic [0:3]    req3_cmd_in,
  input  logic [0:31]   req3_data_in,
  input  logic [0:3]    req4_cmd_in,
  input  logic [0:31]   req4_data_in,
  output logic [0:31]   out_data1,
  output logic [0:1]    out_resp1,
  output logic [0:31]   out_data2,
  output logic [0:1]    out_resp2,
  output logic [0:31]   out_data3,
  output logic [0:1]    out_resp3,
  output logic [0:31]   out_data4,
  output logic [0:1]    out_resp4
);

  // Any asserted reset bit holds the whole block in reset
  logic rst;
  assign rst = |reset;

  // Port-indexed views of the explicitly named ports
  cmd_t  cmd_in  [NPORTS];
  word_t data_in [NPORTS];
  word_t data_q  [NPORTS];
  resp_t resp_q  [NPORTS];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_data1 = data_q[0];
  assign out_resp1 = resp_q[0];
  assign out_data2 = data_q[1];
  assign out_resp2 = resp_q[1];
  assign out_data3 = data_q[2];
  assign out_resp3 = resp_q[2];
  assign out_data4 = data_q[3];
  assign out_resp4 = resp_q[3];

  // ---------------------------------------------------------------------
  // Per-port capture FSMs
  // ---------------------------------------------------------------------
  pstate_t           state_q   [NPORTS];
  pstate_t           state_nxt [NPORTS];
  cmd_t              cmd_q     [NPORTS];
  word_t             op1_q     [NPORTS];
  logic [NPORTS-1:0] cap_vld;
  logic [NPORTS-1:0] push_vld;

  // State register for every port
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) state_q[p] <= P_IDLE;
    end else begin
      for (int p = 0; p < NPORTS; p++) state_q[p] <= state_nxt[p];
    end
  end

  // Next state: a port stays busy through the cycle its answer is on the outputs
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      state_nxt[p] = state_q[p];
      case (state_q[p])
        P_IDLE:  if (cmd_in[p] != CMD_NOP) state_nxt[p] = P_OP2;
        P_OP2:   state_nxt[p] = P_PEND;
        P_PEND:  if (resp_q[p] != RESP_NONE) state_nxt[p] = P_IDLE;
        default: state_nxt[p] = P_IDLE;
      endcase
    end
  end

  // FSM outputs: capture command/operand1 when idle, enqueue on the operand2 cycle
  always_comb begin
    cap_vld  = '0;
    push_vld = '0;
    for (int p = 0; p < NPORTS; p++) begin
      cap_vld[p]  = (state_q[p] == P_IDLE) && (cmd_in[p] != CMD_NOP);
      push_vld[p] = (state_q[p] == P_OP2);
    end
  end

  // Hold command and operand1 until operand2 arrives
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        cmd_q[p] <= CMD_NOP;
        op1_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (cap_vld[p]) begin
          cmd_q[p] <= cmd_in[p];
          op1_q[p] <= data_in[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Ordered request queue. Up to four entries can arrive in one cycle, so
  // this is a compacting shift queue rather than a one-push FIFO. It never
  // overflows: each port has at most one request outstanding.
  // ---------------------------------------------------------------------
  req_t       q_q   [NPORTS];
  req_t       q_nxt [NPORTS];
  logic [2:0] cnt_q;
  logic [2:0] cnt_nxt;
  logic       pop_vld;

  assign pop_vld = (cnt_q != 3'd0);

  // Retire the head, then append new arrivals in ascending port order
  always_comb begin
    q_nxt   = q_q;
    cnt_nxt = cnt_q;
    if (pop_vld) begin
      for (int i = 0; i < NPORTS - 1; i++) q_nxt[i] = q_q[i+1];
      q_nxt[NPORTS-1] = '0;
      cnt_nxt         = cnt_q - 3'd1;
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (push_vld[p]) begin
        q_nxt[cnt_nxt[1:0]] = '{port: PIDW'(p), cmd: cmd_q[p],
                                op1: op1_q[p], op2: data_in[p]};
        cnt_nxt             = cnt_nxt + 3'd1;
      end
    end
  end

  // Queue storage; reset discards everything in flight
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < NPORTS; i++) q_q[i] <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      for (int i = 0; i < NPORTS; i++) q_q[i] <= q_nxt[i];
    end
  end

  // ---------------------------------------------------------------------
  // Shared operation unit and registered per-port outputs
  // ---------------------------------------------------------------------
  word_t alu_dat;
  resp_t alu_resp;

  calc1_alu u_alu (
    .cmd    (q_q[0].cmd),
    .op1    (q_q[0].op1),
    .op2    (q_q[0].op2),
    .result (alu_dat),
    .resp   (alu_resp)
  );

  // Drive the head's result to its own port for one cycle; all others read 0
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        data_q[p] <= '0;
        resp_q[p] <= RESP_NONE;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (pop_vld && (q_q[0].port == PIDW'(p))) begin
          data_q[p] <= alu_dat;
          resp_q[p] <= alu_resp;
        end else begin
          data_q[p] <= '0;
          resp_q[p] <= RESP_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc1_unit.sv
// Scoreboard bench for calc1_unit: expected responses are scheduled at issue time.
// Latency: checks the exact response cycle of every request, every cycle.
// Backpressure: exercises busy-port command drops and queue contention.
module tb_calc1_unit;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [31:0] od  [4];
  logic [1:0]  ors [4];

  always #5 c_clk = ~c_clk;

  calc1_unit dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (dat[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (dat[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (dat[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (dat[3]),
    .out_data1    (out_data1),
    .out_resp1    (out_resp1),
    .out_data2    (out_data2),
    .out_resp2    (out_resp2),
    .out_data3    (out_data3),
    .out_resp3    (out_resp3),
    .out_data4    (out_data4),
    .out_resp4    (out_resp4)
  );

  assign od[0] = out_data1;
  assign od[1] = out_data2;
  assign od[2] = out_data3;
  assign od[3] = out_data4;
  assign ors[0] = out_resp1;
  assign ors[1] = out_resp2;
  assign ors[2] = out_resp3;
  assign ors[3] = out_resp4;

  typedef struct {
    int          port;
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_sched = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  // Every cycle, every port must show either its scheduled answer or all zeros
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      int          idx;
      logic [1:0]  er;
      logic [31:0] ed;
      idx = -1;
      er  = 2'd0;
      ed  = 32'd0;
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].port == p && sb[i].cyc == cyc) idx = i;
      if (idx >= 0) begin
        er = sb[idx].resp;
        ed = sb[idx].data;
        sb.delete(idx);
      end
      n_cmp++;
      if (ors[p] !== er || od[p] !== ed) begin
        n_bad++;
        $display("FAIL port%0d_cycle%0d: resp=%0d data=%h, required resp=%0d data=%h",
                 p + 1, cyc, ors[p], od[p], er, ed);
      end
    end
  end

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // Single server: answer at T+3 unless an earlier request still occupies that slot
  task automatic sched(input int p, input logic [1:0] r, input logic [31:0] d);
    int e;
    e = cyc + 3;
    if (e <= last_sched) e = last_sched + 1;
    last_sched = e;
    sb.push_back('{p, e, r, d});
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] r, input logic [31:0] d);
    sched(p, r, d);
    cmd[p] = c;
    dat[p] = a;
    step();
    cmd[p] = 4'd0;
    dat[p] = b;
    step();
    dat[p] = 32'd0;
  endtask

  // Wait for every scheduled answer plus one cycle so the port is idle again
  task automatic drain(output int left);
    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    step();
    left = sb.size();
  endtask

  task automatic test_reset();
    reset = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = 32'd0;
    end
    step();
    step();
    n_cmp++;
    if ({out_resp1, out_resp2, out_resp3, out_resp4} !== 8'd0 ||
        (out_data1 | out_data2 | out_data3 | out_data4) !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_all: resp=%h data_or=%h, required 0",
               {out_resp1, out_resp2, out_resp3, out_resp4},
               out_data1 | out_data2 | out_data3 | out_data4);
    end
    // A single asserted bit is enough to hold reset, even with a command offered
    reset = 7'b0000001;
    cmd[0] = 4'd1;
    dat[0] = 32'd9;
    step();
    step();
    n_cmp++;
    if ({out_resp1, out_resp2, out_resp3, out_resp4} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_one_bit: resp=%h, required 0",
               {out_resp1, out_resp2, out_resp3, out_resp4});
    end
    cmd[0] = 4'd0;
    dat[0] = 32'd0;
    reset = 7'd0;
    step();
  endtask

  task automatic test_add();
    int left;
    issue(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
    issue(3, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF);
    drain(left);
    issue(0, 4'd1, 32'h0, 32'h0, 2'd1, 32'h0);
    drain(left);
    issue(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_add: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_sub_shift();
    int left;
    issue(0, 4'd2, 32'd5, 32'd7, 2'd2, 32'h0);
    drain(left);
    issue(0, 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
    drain(left);
    issue(0, 4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd1, 32'h0);
    drain(left);
    issue(0, 4'd5, 32'h0000_0001, 32'd31, 2'd1, 32'h8000_0000);
    drain(left);
    issue(0, 4'd6, 32'h8000_0000, 32'h23, 2'd1, 32'h1000_0000);
    drain(left);
    issue(0, 4'd5, 32'hF000_000F, 32'hFFFF_FFE4, 2'd1, 32'h0000_00F0);
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_sub_shift: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_invalid();
    int          left;
    logic [3:0]  bad_cmds [4];
    bad_cmds = '{4'd3, 4'd4, 4'd15, 4'd7};
    for (int i = 0; i < 4; i++) begin
      issue(1, bad_cmds[i], 32'd10, 32'd3, 2'd2, 32'h0);
      drain(left);
    end
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_invalid: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_busy();
    int left;
    sched(1, 2'd1, 32'd30);
    cmd[1] = 4'd1;
    dat[1] = 32'd10;
    step();
    dat[1] = 32'd20;
    step();
    dat[1] = 32'd99;
    step();
    step();
    cmd[1] = 4'd0;
    dat[1] = 32'd0;
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_busy: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_all_ports();
    int          left;
    logic [31:0] a [4];
    logic [31:0] b [4];
    a = '{32'h0000_0101, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    b = '{32'h0000_1000, 32'h1111_1111, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
    for (int p = 0; p < 3; p++) sched(p, 2'd1, a[p] + b[p]);
    sched(3, 2'd2, 32'h0);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      dat[p] = a[p];
    end
    step();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = b[p];
    end
    step();
    for (int p = 0; p < 4; p++) dat[p] = 32'd0;
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_all_ports: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_order();
    int left;
    sched(2, 2'd1, 32'd300);
    cmd[2] = 4'd1;
    dat[2] = 32'd100;
    step();
    sched(0, 2'd1, 32'd3);
    cmd[2] = 4'd0;
    dat[2] = 32'd200;
    cmd[0] = 4'd2;
    dat[0] = 32'd10;
    step();
    cmd[0] = 4'd0;
    dat[0] = 32'd7;
    dat[2] = 32'd0;
    step();
    dat[0] = 32'd0;
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_order: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int left;
    sched(0, 2'd1, 32'd11);
    cmd[0] = 4'd1;
    dat[0] = 32'd5;
    step();
    // Abort between operand1 and operand2: the request must vanish
    reset = 7'b0100000;
    sb.delete();
    last_sched = 0;
    cmd[0] = 4'd0;
    dat[0] = 32'd6;
    step();
    dat[0] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (out_resp1 !== 2'd0 || out_data1 !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_mid_out1: resp=%0d data=%h, required 0", out_resp1, out_data1);
      end
    end
    reset = 7'd0;
    step();
    step();
    issue(0, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);
    drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL drain_reset_mid: outstanding=%0d, required 0", left);
      sb.delete();
    end
  endtask

  initial begin
    reset = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = 32'd0;
    end
    test_reset();
    test_add();
    test_sub_shift();
    test_invalid();
    test_busy();
    test_all_ports();
    test_order();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
